// File: rtl/tetris_piece_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Piece ids, cell masks, heights and FSM encoding shared by the
//               falling-piece sprite address generator.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

  localparam logic [2:0] c_PIECE_I = 3'd0;
  localparam logic [2:0] c_PIECE_J = 3'd1;
  localparam logic [2:0] c_PIECE_L = 3'd2;
  localparam logic [2:0] c_PIECE_O = 3'd3;
  localparam logic [2:0] c_PIECE_S = 3'd4;
  localparam logic [2:0] c_PIECE_T = 3'd5;
  localparam logic [2:0] c_PIECE_Z = 3'd6;

  // Mask bit index is row*2+col inside the 2-wide, 4-tall bounding box.
  localparam logic [7:0] c_MASK_I = 8'h55;
  localparam logic [7:0] c_MASK_J = 8'h3A;
  localparam logic [7:0] c_MASK_L = 8'h35;
  localparam logic [7:0] c_MASK_O = 8'h0F;
  localparam logic [7:0] c_MASK_S = 8'h2D;
  localparam logic [7:0] c_MASK_T = 8'h2E;
  localparam logic [7:0] c_MASK_Z = 8'h1E;

  // Entry 7 aliases the I piece.
  localparam logic [7:0][7:0] c_MASK_TABLE = {
    c_MASK_I, c_MASK_Z, c_MASK_T, c_MASK_S,
    c_MASK_O, c_MASK_L, c_MASK_J, c_MASK_I
  };

  localparam logic [7:0][2:0] c_HEIGHT_TABLE = {
    3'd4, 3'd3, 3'd3, 3'd3,
    3'd2, 3'd3, 3'd3, 3'd4
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FALLING = 2'd1,
    ST_LANDED  = 2'd2
  } state_t;

  function automatic logic [2:0] norm_piece(input logic [2:0] id);
    return (id == 3'd7) ? c_PIECE_I : id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tetris_piece_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : tetris_piece_addr_gen_if
// Description : Spawn/tick control, VGA counters and sprite-address outputs
//               of the falling-piece address generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface tetris_piece_addr_gen_if #(
  parameter int ADDR_W = 17
);

  logic              tick;
  logic              spawn_valid;
  logic [2:0]        spawn_piece;
  logic              spawn_ready;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic [ADDR_W-1:0] pixel_addr;
  logic              pixel_valid;
  logic [9:0]        position;
  logic              landed;

  modport master (
    output tick, spawn_valid, spawn_piece, h_cnt, v_cnt,
    input  spawn_ready, pixel_addr, pixel_valid, position, landed
  );

  modport slave (
    input  tick, spawn_valid, spawn_piece, h_cnt, v_cnt,
    output spawn_ready, pixel_addr, pixel_valid, position, landed
  );

endinterface
`default_nettype wire

// File: rtl/tetris_piece_addr_gen_piece_mask_lookup.sv
`default_nettype none
// ============================================================================
// Module      : piece_mask_lookup
// Description : Combinational (id, row, col) -> cell-set bit, and id -> height.
// Revision    : 1.0 - initial release
// ============================================================================
module piece_mask_lookup
  import tetris_pkg::*;
(
  input  logic [2:0] piece_id,
  input  logic [1:0] row,
  input  logic       col,
  output logic       hit,
  output logic [2:0] height
);

  logic [7:0] w_mask;

  always_comb begin
    w_mask = c_MASK_TABLE[piece_id];
    height = c_HEIGHT_TABLE[piece_id];
    hit    = w_mask[{row, col}];
  end

endmodule
`default_nettype wire

// File: rtl/tetris_piece_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tetris_piece_addr_gen
// Description : Falling tetromino FSM, drop counter and registered sprite-sheet
//               ROM address / pixel-valid generation for the VGA datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tetris_piece_addr_gen
  import tetris_pkg::*;
#(
  parameter int CELL         = 32,
  parameter int X_ORIGIN     = 288,
  parameter int FLOOR_Y      = 480,
  parameter int STEP         = 32,
  parameter int SHEET_W      = 416,
  parameter int PIECE_STRIDE = 64,
  parameter int ADDR_W       = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  tetris_piece_addr_gen_if.slave  bus
);

  localparam int c_CELL_SH = $clog2(CELL);
  localparam int c_BOX_W   = 2 * CELL;
  localparam int c_BOX_H   = 4 * CELL;

  state_t      r_state;
  state_t      w_state_next;
  logic [9:0]  r_position;
  logic [9:0]  w_position_next;
  logic [2:0]  r_piece;
  logic [2:0]  w_piece_next;

  logic [31:0] w_dx;
  logic [31:0] w_dy;
  logic        w_in_x;
  logic        w_in_y;
  logic [1:0]  w_row;
  logic        w_col;
  logic        w_mask_hit;
  logic [2:0]  w_height;
  logic [31:0] w_drop_bottom;
  logic        w_fits;
  logic        w_hit;
  logic [ADDR_W-1:0] w_addr;

  logic [ADDR_W-1:0] r_pixel_addr;
  logic              r_pixel_valid;

  piece_mask_lookup u_mask (
    .piece_id (r_piece),
    .row      (w_row),
    .col      (w_col),
    .hit      (w_mask_hit),
    .height   (w_height)
  );

  // Bottom edge after one more step, compared against the floor without wrap.
  assign w_drop_bottom = 32'(r_position) + (32'(w_height) << c_CELL_SH) + 32'(STEP);
  assign w_fits        = (w_drop_bottom <= 32'(FLOOR_Y));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_position <= '0;
      r_piece    <= c_PIECE_I;
    end else begin
      r_state    <= w_state_next;
      r_position <= w_position_next;
      r_piece    <= w_piece_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_position_next = r_position;
    w_piece_next    = r_piece;
    case (r_state)
      ST_IDLE: begin
        if (bus.spawn_valid) begin
          w_state_next    = ST_FALLING;
          w_position_next = '0;
          w_piece_next    = norm_piece(bus.spawn_piece);
        end
      end
      ST_FALLING: begin
        if (bus.tick) begin
          if (w_fits) begin
            w_position_next = r_position + 10'(STEP);
          end else begin
            w_state_next = ST_LANDED;
          end
        end
      end
      ST_LANDED: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Pixel path works off the registered position; offsets are only meaningful
  // once the unsigned range checks pass.
  assign w_dx   = 32'(bus.h_cnt) - 32'(X_ORIGIN);
  assign w_dy   = 32'(bus.v_cnt) - 32'(r_position);
  assign w_in_x = (32'(bus.h_cnt) >= 32'(X_ORIGIN)) && (w_dx < 32'(c_BOX_W));
  assign w_in_y = (bus.v_cnt >= r_position) && (w_dy < 32'(c_BOX_H));
  assign w_row  = w_dy[c_CELL_SH+1:c_CELL_SH];
  assign w_col  = w_dx[c_CELL_SH];
  assign w_hit  = w_in_x && w_in_y && w_mask_hit && (r_state != ST_IDLE);
  assign w_addr = ADDR_W'(w_dy * 32'(SHEET_W) + 32'(r_piece) * 32'(PIECE_STRIDE) + w_dx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixel_addr  <= '0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_pixel_valid <= w_hit;
      r_pixel_addr  <= w_hit ? w_addr : '0;
    end
  end

  assign bus.pixel_addr  = r_pixel_addr;
  assign bus.pixel_valid = r_pixel_valid;
  assign bus.position    = r_position;
  assign bus.spawn_ready = (r_state == ST_IDLE);
  assign bus.landed      = (r_state == ST_LANDED);

endmodule
`default_nettype wire

// File: tb/tb_tetris_piece_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tetris_piece_addr_gen
// Description : Scoreboard bench with a shape-table reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tetris_piece_addr_gen;

  localparam int CELL = 32, X0 = 288, FLOOR = 480, STEP = 32;
  localparam int SHEET_W = 416, PSTR = 64, ADDR_W = 17;

  typedef struct {
    int valid;
    int addr;
    int pos;
    int landed;
    int ready;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tetris_piece_addr_gen_if #(.ADDR_W(ADDR_W)) bus ();

  tetris_piece_addr_gen #(
    .CELL(CELL), .X_ORIGIN(X0), .FLOOR_Y(FLOOR), .STEP(STEP),
    .SHEET_W(SHEET_W), .PIECE_STRIDE(PSTR), .ADDR_W(ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  string shape[7][4];
  int    m_state = 0;  // 0 idle, 1 falling, 2 landed
  int    m_pos = 0;
  int    m_id = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit cell_set(input int id, input int r, input int c);
    string s;
    s = shape[id][r];
    return s.getc(c) == "X";
  endfunction

  function automatic int height(input int id);
    int h = 0;
    for (int r = 0; r < 4; r++)
      if (cell_set(id, r, 0) || cell_set(id, r, 1)) h = r + 1;
    return h;
  endfunction

  // Expectation is formed from the pre-edge model, pushed at the edge.
  task automatic step(input bit sv, input int sp, input bit tk, input int h, input int v);
    exp_t e;
    int dx, dy;
    bus.spawn_valid = sv;
    bus.spawn_piece = 3'(sp);
    bus.tick        = tk;
    bus.h_cnt       = 10'(h);
    bus.v_cnt       = 10'(v);
    dx = h - X0;
    dy = v - m_pos;
    e.valid = 0;
    e.addr  = 0;
    if (m_state != 0 && dx >= 0 && dx < 2*CELL && dy >= 0 && dy < 4*CELL &&
        cell_set(m_id, dy / CELL, dx / CELL)) begin
      e.valid = 1;
      e.addr  = (dy * SHEET_W + m_id * PSTR + dx) % (1 << ADDR_W);
    end
    case (m_state)
      0: if (sv) begin m_id = (sp == 7) ? 0 : sp; m_pos = 0; m_state = 1; end
      1: if (tk) begin
           if (m_pos + height(m_id) * CELL + STEP <= FLOOR) m_pos += STEP;
           else m_state = 2;
         end
      default: m_state = 0;
    endcase
    e.pos    = m_pos;
    e.landed = (m_state == 2) ? 1 : 0;
    e.ready  = (m_state == 0) ? 1 : 0;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic sweep(input bit sv, input int sp);
    for (int r = -1; r < 5; r++)
      for (int c = -1; c < 3; c++)
        step(sv, sp, 1'b0, X0 + c*CELL + int'($urandom_range(0, CELL-1)),
             m_pos + r*CELL + int'($urandom_range(0, CELL-1)));
  endtask

  task automatic land();
    int n = 0;
    while (m_state != 0 && n < 40) begin
      step(1'b0, 0, 1'b1, 300, m_pos + 5);
      n++;
    end
    check("land_bound", m_state, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      check("pixel_valid", int'(bus.pixel_valid), e.valid);
      check("pixel_addr",  int'(bus.pixel_addr),  e.addr);
      check("position",    int'(bus.position),    e.pos);
      check("landed",      int'(bus.landed),      e.landed);
      check("spawn_ready", int'(bus.spawn_ready), e.ready);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    shape[0] = '{"X.", "X.", "X.", "X."};
    shape[1] = '{".X", ".X", "XX", ".."};
    shape[2] = '{"X.", "X.", "XX", ".."};
    shape[3] = '{"XX", "XX", "..", ".."};
    shape[4] = '{"X.", "XX", ".X", ".."};
    shape[5] = '{".X", "XX", ".X", ".."};
    shape[6] = '{".X", "XX", "X.", ".."};
    bus.tick = 1'b0; bus.spawn_valid = 1'b0; bus.spawn_piece = 3'd0;
    bus.h_cnt = 10'd0; bus.v_cnt = 10'd0;

    repeat (2) @(posedge clk);
    #2;
    check("rst_position",    int'(bus.position),    0);
    check("rst_spawn_ready", int'(bus.spawn_ready), 1);
    check("rst_pixel_valid", int'(bus.pixel_valid), 0);
    check("rst_pixel_addr",  int'(bus.pixel_addr),  0);
    check("rst_landed",      int'(bus.landed),      0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // O piece address, then T mask hole and set cell
    step(1'b1, 3, 1'b0, 0, 0);
    step(1'b0, 0, 1'b0, 300, 10);
    sweep(1'b0, 0);
    land();
    step(1'b1, 5, 1'b0, 0, 0);
    step(1'b0, 0, 1'b0, 300, 10);
    step(1'b0, 0, 1'b0, 300, 40);
    land();

    // I piece: 11 steps to 352, 12th tick lands
    step(1'b1, 0, 1'b0, 0, 0);
    for (int i = 0; i < 11; i++) step(1'b0, 0, 1'b1, 290, m_pos + 100);
    step(1'b0, 0, 1'b1, 290, m_pos + 100);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 290, m_pos + 100);

    // Spawn requests ignored while a piece falls
    step(1'b1, 4, 1'b0, 0, 0);
    step(1'b1, 2, 1'b1, 300, 40);
    sweep(1'b1, 2);
    land();

    // Spawn with tick in idle, id 7 renders as I
    step(1'b1, 7, 1'b1, 0, 0);
    sweep(1'b0, 0);
    land();

    // Async reset mid-fall at position 96
    step(1'b1, 1, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 300, 100);
    step(1'b0, 0, 1'b0, 300, 96 + 80);
    #2 rst = 1'b1;
    #1;
    check("midrst_position",    int'(bus.position),    0);
    check("midrst_spawn_ready", int'(bus.spawn_ready), 1);
    check("midrst_pixel_valid", int'(bus.pixel_valid), 0);
    check("midrst_landed",      int'(bus.landed),      0);
    sb.delete();
    m_state = 0; m_pos = 0; m_id = 0;
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 2500; i++) begin
      int v;
      v = m_pos - 8 + int'($urandom_range(0, 150));
      if (v < 0) v = 0;
      step(($urandom % 6) == 0, int'($urandom % 8), ($urandom % 3) == 0,
           270 + int'($urandom % 100), v);
    end

    step(1'b0, 0, 1'b0, 0, 0);
    @(negedge clk); #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tetris_piece_addr_gen.md
# tetris_piece_addr_gen

Parametrised falling-piece sprite address generator for the VGA Tetris datapath. It sits between the VGA timing counters and the sprite-sheet block ROM. It accepts a spawn request for one of seven tetrominoes and steps the piece down the playfield on an external drop tick. It detects landing against a configurable floor and emits a registered ROM address plus pixel-valid for every pixel covered by the piece's cell mask.

## Interface

Parameters:
- CELL, 32: cell edge in pixels; must be a power of two.
- X_ORIGIN, 288: left pixel column of the piece bounding box.
- FLOOR_Y, 480: first pixel row below the playfield.
- STEP, 32: pixels moved per drop tick.
- SHEET_W, 416: sprite-sheet row stride in pixels.
- PIECE_STRIDE, 64: horizontal sheet offset between consecutive piece sprites.
- ADDR_W, 17: ROM address width.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  pixel-domain clock.
- rst  in  1  async active-high reset.
- tick  in  1  single-cycle drop-step enable.
- spawn_valid  in  1  request to spawn a new piece.
- spawn_piece  in  3  piece id 0..7; id 7 is treated as id 0 (I).
- spawn_ready  out  1  high only in IDLE.
- h_cnt  in  10  VGA column.
- v_cnt  in  10  VGA row.
- pixel_addr  out  ADDR_W  ROM address, registered.
- pixel_valid  out  1  pixel lies on a set mask cell, registered.
- position  out  10  top pixel row of the bounding box.
- landed  out  1  one-cycle pulse on landing.

## Operation

- Bounding box is 2 cells wide by 4 cells tall. Mask bit index is row*2+col.
- Masks (row:cols):
  - 0 I: r0-3:c0.
  - 1 J: r0-2:c1, r2:c0.
  - 2 L: r0-2:c0, r2:c1.
  - 3 O: r0-1:c0,c1.
  - 4 S: r0-1:c0, r1-2:c1.
  - 5 T: r1:c0, r0-2:c1.
  - 6 Z: r0-1:c1, r1-2:c0.
- Piece height in rows: I=4, O=2, all others 3.
- FSM IDLE / FALLING / LANDED:
  - IDLE: when spawn_valid is high, latch the piece id, set position=0, go to FALLING.
  - FALLING: on tick, if position + height*CELL + STEP <= FLOOR_Y, add STEP to position. Otherwise go to LANDED and leave position unchanged.
  - LANDED: assert landed for exactly one cycle, then return to IDLE. position holds until the next spawn.
- Ignored inputs:
  - spawn_valid outside IDLE.
  - tick in IDLE and in LANDED.
  - A tick in the same cycle as a spawn.
- Pixel hit, per cycle:
  - dx = h_cnt - X_ORIGIN, dy = v_cnt - position.
  - Hit when h_cnt >= X_ORIGIN, dx < 2*CELL, v_cnt >= position, dy < 4*CELL, the mask bit [dy/CELL][dx/CELL] is set, and state != IDLE.
- On a hit, pixel_addr = dy*SHEET_W + id*PIECE_STRIDE + dx, truncated to ADDR_W.
- On a miss, pixel_addr = 0 and pixel_valid = 0.
- Arithmetic rules:
  - All comparisons are unsigned on width-extended operands; no wrap on position + offsets.
  - Divisions by CELL are shifts.

## Timing

- Reset values:
  - state=IDLE, position=0, piece id=0.
  - pixel_addr=0, pixel_valid=0, landed=0.
  - spawn_ready=1.
- pixel_addr and pixel_valid have a latency of 1 clk from h_cnt/v_cnt.
- position updates on the clk edge that samples tick. The pixel path uses the registered position.
- spawn handshake: a transfer occurs on a clk edge where spawn_valid && spawn_ready. spawn_ready drops on the following cycle.
- landed is high on the cycle after the rejecting tick. spawn_ready returns on the cycle after that.
- Reset asserted mid-fall forces IDLE and position 0 immediately. The pixel outputs clear asynchronously.

## Structure

- Package tetris_pkg holds:
  - the piece-id localparams;
  - the 8-bit mask constants;
  - the per-piece height table;
  - the state enum encoding.
- One sub-module, piece_mask_lookup: combinational lookup of (id, row, col) to a hit bit, plus id to height.
- The FSM, position counter and output register live in the top module.

## Test plan

- Reset check: assert rst mid-fall with position=96. Required: position=0, state IDLE, spawn_ready=1, pixel_valid=0 in the same cycle.
- Address check: spawn O (3), no tick, h=300, v=10. Required, one clk later: pixel_addr=4364, pixel_valid=1.
- Mask-hole check: spawn T (5) at position 0, h=300, v=10 (r0,c0 clear). Required: pixel_addr=0, pixel_valid=0. With v=40 (r1,c0 set), required: pixel_addr=40*416+320+12=16972.
- I-piece fall: spawn I, then issue 11 ticks. Required: position=352. The 12th tick leaves position at 352 and landed pulses once. spawn_ready is high two cycles after that tick.
- Spawn rejection: hold spawn_valid with id 2 during FALLING. Required: the latched id and position are unchanged.
- Simultaneous events: spawn and tick in the same cycle in IDLE. Required: position=0 and no step. Id 7 renders identically to id 0.
